// File: rtl/npu_rd_return_pkg.sv
// Shared types and constants for the NPU read-return bridge.
// Optional feature macro used by the design: NPU_RD_ERR_RESP_EN.
package npu_rd_return_pkg;

   localparam int unsigned ID_W   = 4;
   localparam int unsigned LEN_W  = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned AR_W   = ID_W + LEN_W;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_STREAM = 2'd2,
      ST_ERRB   = 2'd3
   } rd_state_e;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [LEN_W-1:0] len;
   } ar_entry_t;

endpackage

// File: rtl/sync_fifo_sr.sv
// Synchronous-reset first-word-fall-through FIFO; rdata always shows the head entry.
module sync_fifo_sr #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/npu_rd_return.sv
// AXI read-return bridge: queues AR requests, triggers NPU reads and streams the data back.
// Define NPU_RD_ERR_RESP_EN to forward per-beat NPU error flags as SLVERR.
module npu_rd_return
   import npu_rd_return_pkg::*;
#(
   parameter int unsigned AR_DEPTH   = 4,
   parameter int unsigned DATA_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ID_W-1:0]   acc_arid,
   input  logic [31:0]       acc_araddr,
   input  logic [LEN_W-1:0]  acc_arlen,
   input  logic [2:0]        acc_arsize,
   input  logic [1:0]        acc_arburst,
   input  logic [2:0]        acc_arprot,
   input  logic              acc_arvalid,
   output logic              acc_arready,
   output logic [ID_W-1:0]   acc_rid,
   output logic [DATA_W-1:0] acc_rdata,
   output logic [1:0]        acc_rresp,
   output logic              acc_rlast,
   output logic              acc_rvalid,
   input  logic              acc_rready,
   output logic              npu_rd_sop_data,
   input  logic              npu_rd_eop_data,
   input  logic              npu_rd_vld_data,
   input  logic [DATA_W-1:0] npu_rd_data_data,
   input  logic              npu_rd_err,
   output logic              rd_ovf
);

`ifdef NPU_RD_ERR_RESP_EN
   localparam int unsigned BUF_W = DATA_W + 1;
`else
   localparam int unsigned BUF_W = DATA_W;
`endif

   rd_state_e         state_q, state_d;
   logic [ID_W-1:0]   id_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [LEN_W:0]    in_cnt_q;
   logic              ovf_q;
   logic              rdy_q;

   ar_entry_t         ar_in, ar_head;
   logic              ar_push, ar_pop, ar_full, ar_empty;
   logic [BUF_W-1:0]  d_wdata, d_head;
   logic              d_push, d_pop, d_full, d_empty, d_drop;
   logic              fits, r_hs, stream_vld;
   logic              unused_ok;

   assign ar_in   = '{id: acc_arid, len: acc_arlen};
   assign ar_push = acc_arvalid && acc_arready;
   assign fits    = (32'(ar_head.len) + 32'd1) <= 32'(DATA_DEPTH);

   sync_fifo_sr #(.DEPTH(AR_DEPTH), .WIDTH(AR_W)) u_ar_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ar_push),
      .wdata (ar_in),
      .pop   (ar_pop),
      .rdata (ar_head),
      .full  (ar_full),
      .empty (ar_empty)
   );

`ifdef NPU_RD_ERR_RESP_EN
   assign d_wdata   = {npu_rd_err, npu_rd_data_data};
   assign unused_ok = ^{acc_araddr, acc_arsize, acc_arburst, acc_arprot, npu_rd_eop_data};
`else
   assign d_wdata   = npu_rd_data_data;
   assign unused_ok = ^{acc_araddr, acc_arsize, acc_arburst, acc_arprot, npu_rd_eop_data,
                        npu_rd_err};
`endif

   // Only the beats the burst asked for are buffered; anything else is dropped and flagged.
   assign d_push = npu_rd_vld_data && ((state_q == ST_REQ) || (state_q == ST_STREAM))
                   && !d_full && (in_cnt_q <= {1'b0, len_q});
   assign d_drop = npu_rd_vld_data && !d_push;

   sync_fifo_sr #(.DEPTH(DATA_DEPTH), .WIDTH(BUF_W)) u_data_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (d_push),
      .wdata (d_wdata),
      .pop   (d_pop),
      .rdata (d_head),
      .full  (d_full),
      .empty (d_empty)
   );

   // R channel is a pure function of registered state and the FWFT buffer head.
   assign stream_vld      = (state_q == ST_STREAM) && !d_empty;
   assign acc_rvalid      = stream_vld || (state_q == ST_ERRB);
   assign acc_rid         = id_q;
   assign acc_rdata       = stream_vld ? d_head[DATA_W-1:0] : '0;
   assign acc_rlast       = acc_rvalid && (cnt_q == len_q);
   assign acc_arready     = rdy_q && !ar_full;
   assign npu_rd_sop_data = (state_q == ST_REQ);
   assign rd_ovf          = ovf_q;
   assign r_hs            = acc_rvalid && acc_rready;

   always_comb begin
      acc_rresp = RESP_OKAY;
      if (state_q == ST_ERRB) begin
         acc_rresp = RESP_SLVERR;
`ifdef NPU_RD_ERR_RESP_EN
      end else if (stream_vld && d_head[DATA_W]) begin
         acc_rresp = RESP_SLVERR;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      ar_pop  = 1'b0;
      d_pop   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!ar_empty && d_empty) begin
               ar_pop  = 1'b1;
               state_d = fits ? ST_REQ : ST_ERRB;
            end
         end
         ST_REQ:    state_d = ST_STREAM;
         ST_STREAM: begin
            d_pop = r_hs;
            if (r_hs && acc_rlast) state_d = ST_IDLE;
         end
         ST_ERRB: begin
            if (r_hs && acc_rlast) state_d = ST_IDLE;
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         id_q     <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         in_cnt_q <= '0;
         ovf_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= 1'b1;
         if (ar_pop) begin
            id_q     <= ar_head.id;
            len_q    <= ar_head.len;
            cnt_q    <= '0;
            in_cnt_q <= '0;
         end else begin
            if (r_hs)   cnt_q    <= cnt_q + LEN_W'(1);
            if (d_push) in_cnt_q <= in_cnt_q + (LEN_W + 1)'(1);
         end
         if (d_drop) ovf_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_npu_rd_return.sv
// Directed scoreboard bench for npu_rd_return (default parameters).
module tb_npu_rd_return;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rbeat_t;

`ifdef NPU_RD_ERR_RESP_EN
   localparam logic [1:0] ERR_RESP = 2'b10;
`else
   localparam logic [1:0] ERR_RESP = 2'b00;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  acc_arid;
   logic [31:0] acc_araddr;
   logic [7:0]  acc_arlen;
   logic [2:0]  acc_arsize;
   logic [1:0]  acc_arburst;
   logic [2:0]  acc_arprot;
   logic        acc_arvalid;
   logic        acc_arready;
   logic [3:0]  acc_rid;
   logic [31:0] acc_rdata;
   logic [1:0]  acc_rresp;
   logic        acc_rlast;
   logic        acc_rvalid;
   logic        acc_rready;
   logic        npu_rd_sop_data;
   logic        npu_rd_eop_data;
   logic        npu_rd_vld_data;
   logic [31:0] npu_rd_data_data;
   logic        npu_rd_err;
   logic        rd_ovf;

   int     tests = 0;
   int     fails = 0;
   int     sop_cnt = 0;
   int     exp_sop = 0;
   rbeat_t exp_q[$];
   rbeat_t rb;

   npu_rd_return dut (
      .clk              (clk),
      .rst              (rst),
      .acc_arid         (acc_arid),
      .acc_araddr       (acc_araddr),
      .acc_arlen        (acc_arlen),
      .acc_arsize       (acc_arsize),
      .acc_arburst      (acc_arburst),
      .acc_arprot       (acc_arprot),
      .acc_arvalid      (acc_arvalid),
      .acc_arready      (acc_arready),
      .acc_rid          (acc_rid),
      .acc_rdata        (acc_rdata),
      .acc_rresp        (acc_rresp),
      .acc_rlast        (acc_rlast),
      .acc_rvalid       (acc_rvalid),
      .acc_rready       (acc_rready),
      .npu_rd_sop_data  (npu_rd_sop_data),
      .npu_rd_eop_data  (npu_rd_eop_data),
      .npu_rd_vld_data  (npu_rd_vld_data),
      .npu_rd_data_data (npu_rd_data_data),
      .npu_rd_err       (npu_rd_err),
      .rd_ovf           (rd_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [7:0] len);
      logic ok;
      ok          = 1'b0;
      acc_arid    = id;
      acc_arlen   = len;
      acc_araddr  = $urandom;
      acc_arvalid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (acc_arready) ok = 1'b1;
         tick(1);
      end
      acc_arvalid = 1'b0;
      chk("ar_accept", 64'(ok), 64'(1));
   endtask

   task automatic npu_beat(input logic [31:0] d, input logic e);
      npu_rd_vld_data  = 1'b1;
      npu_rd_data_data = d;
      npu_rd_err       = e;
      tick(1);
      npu_rd_vld_data  = 1'b0;
      npu_rd_err       = 1'b0;
   endtask

   task automatic wait_sop();
      exp_sop++;
      for (int i = 0; i < 200 && sop_cnt < exp_sop; i++) tick(1);
      chk("sop_seen", 64'(sop_cnt), 64'(exp_sop));
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick(1);
      chk("drain", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic push_exp(input logic [3:0] id, input logic [31:0] d,
                           input logic [1:0] resp, input logic last);
      rbeat_t e;
      e = '{id: id, data: d, resp: resp, last: last};
      exp_q.push_back(e);
   endtask

   // Scoreboard: every R handshake must match the oldest expected beat.
   always @(negedge clk) begin
      if (npu_rd_sop_data) sop_cnt++;
      if (!rst && acc_rvalid && acc_rready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(1), 64'(0));
         end else begin
            rb = exp_q.pop_front();
            chk("rbeat", 64'({acc_rid, acc_rdata, acc_rresp, acc_rlast}), 64'(rb));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      acc_arid = '0; acc_araddr = '0; acc_arlen = '0; acc_arsize = 3'd2;
      acc_arburst = 2'b01; acc_arprot = '0; acc_arvalid = 1'b0; acc_rready = 1'b1;
      npu_rd_eop_data = 1'b0; npu_rd_vld_data = 1'b0; npu_rd_data_data = '0; npu_rd_err = 1'b0;

      // Reset state
      tick(3);
      chk("reset_outputs", 64'({acc_arready, acc_rvalid, acc_rid, acc_rdata, acc_rresp,
                                acc_rlast, npu_rd_sop_data, rd_ovf}), 64'(0));
      rst = 1'b0;
      tick(2);
      chk("arready_after_reset", 64'(acc_arready), 64'(1));

      // Single 4-beat burst, sop exactly one cycle after the pop
      send_ar(4'd3, 8'd3);
      chk("sop_before", 64'(npu_rd_sop_data), 64'(0));
      tick(1);
      chk("sop_pulse", 64'(npu_rd_sop_data), 64'(1));
      exp_sop++;
      for (int i = 0; i < 4; i++) begin
         push_exp(4'd3, 32'hA000_0000 + 32'(i), 2'b00, i == 3);
         npu_beat(32'hA000_0000 + 32'(i), 1'b0);
      end
      chk("sop_after", 64'(npu_rd_sop_data), 64'(0));
      drain();
      chk("sop_count_t1", 64'(sop_cnt), 64'(exp_sop));

      // Three back-to-back single-beat bursts returned in order
      send_ar(4'd1, 8'd0);
      chk("arready_b2b_1", 64'(acc_arready), 64'(1));
      send_ar(4'd2, 8'd0);
      chk("arready_b2b_2", 64'(acc_arready), 64'(1));
      send_ar(4'd5, 8'd0);
      chk("arready_b2b_3", 64'(acc_arready), 64'(1));
      begin
         logic [3:0] ids [3];
         ids[0] = 4'd1; ids[1] = 4'd2; ids[2] = 4'd5;
         for (int k = 0; k < 3; k++) begin
            wait_sop();
            push_exp(ids[k], 32'hB000_0000 + 32'(k), 2'b00, 1'b1);
            npu_beat(32'hB000_0000 + 32'(k), 1'b0);
         end
      end
      drain();
      chk("ovf_clear_t2", 64'(rd_ovf), 64'(0));

      // Oversized burst: 21 SLVERR beats, no NPU request
      send_ar(4'd7, 8'd20);
      for (int i = 0; i <= 20; i++) push_exp(4'd7, 32'h0, 2'b10, i == 20);
      drain();
      chk("errb_no_sop", 64'(sop_cnt), 64'(exp_sop));
      chk("ovf_clear_t3", 64'(rd_ovf), 64'(0));

      // Backpressure hold, surplus beat dropped
      acc_rready = 1'b0;
      send_ar(4'd4, 8'd1);
      wait_sop();
      npu_beat(32'hC0DE_0000, 1'b0);
      npu_beat(32'hC0DE_0001, 1'b0);
      npu_beat(32'hC0DE_0002, 1'b0);
      tick(1);
      chk("ovf_set", 64'(rd_ovf), 64'(1));
      for (int i = 0; i < 5; i++) begin
         chk("hold", 64'({acc_rvalid, acc_rid, acc_rdata, acc_rresp, acc_rlast}),
             64'({1'b1, 4'd4, 32'hC0DE_0000, 2'b00, 1'b0}));
         tick(1);
      end
      push_exp(4'd4, 32'hC0DE_0000, 2'b00, 1'b0);
      push_exp(4'd4, 32'hC0DE_0001, 2'b00, 1'b1);
      acc_rready = 1'b1;
      drain();
      tick(3);
      chk("no_surplus", 64'(acc_rvalid), 64'(0));

      // Per-beat error flag
      send_ar(4'd9, 8'd3);
      wait_sop();
      for (int i = 0; i < 4; i++) begin
         push_exp(4'd9, 32'hD000_0000 + 32'(i), (i == 2) ? ERR_RESP : 2'b00, i == 3);
         npu_beat(32'hD000_0000 + 32'(i), i == 2);
      end
      drain();
      chk("ovf_sticky", 64'(rd_ovf), 64'(1));

      // AR queue fills, then reset mid-burst
      acc_rready = 1'b0;
      send_ar(4'd10, 8'd3);
      chk("arready_fill_1", 64'(acc_arready), 64'(1));
      for (int k = 0; k < 4; k++) begin
         send_ar(4'(11 + k), 8'd0);
         chk("arready_fill", 64'(acc_arready), 64'(k < 3));
      end
      exp_sop++;
      acc_arid = 4'd15; acc_arvalid = 1'b1;
      tick(2);
      chk("arready_full_hold", 64'(acc_arready), 64'(0));
      acc_arvalid = 1'b0;
      npu_beat(32'hE000_0000, 1'b0);
      tick(1);
      chk("midburst_valid", 64'(acc_rvalid), 64'(1));
      rst = 1'b1;
      tick(1);
      chk("reset_midburst", 64'({acc_arready, acc_rvalid, acc_rid, acc_rdata, acc_rresp,
                                 acc_rlast, npu_rd_sop_data, rd_ovf}), 64'(0));
      rst = 1'b0;
      acc_rready = 1'b1;
      tick(20);
      chk("post_reset_idle", 64'({acc_arready, acc_rvalid}), 64'({1'b1, 1'b0}));
      chk("post_reset_no_sop", 64'(sop_cnt), 64'(exp_sop));
      chk("post_reset_queue", 64'(exp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
